// File: rtl/ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// ps2_key_event_decoder
//
// Drains the scan-code FIFO of ps2_keyboard one byte at a time, folds the
// PS/2 set-2 E0 (extended) and F0 (break) prefixes into the following code,
// and presents one complete key event per final code on a valid/ready port.
// Every event carries make/break, extended and typematic-repeat flags, an
// ASCII translation and the live shift/ctrl state.
//
// Optional feature (macro PS2_REPEAT_FILTER_EN):
//   defined   - typematic repeat makes are swallowed (no event is emitted)
//               and evt_repeat is always 0.
//   undefined - repeat makes are emitted with evt_repeat=1.
//
// Parameters:
//   CNT_W          width of press_cnt
//
// Ports:
//   clk            system clock
//   rst            asynchronous, active-low reset
//   kbd_data       FIFO head byte from ps2_keyboard
//   kbd_ready      FIFO non-empty, kbd_data valid
//   kbd_nextdata_n active-low one-cycle pop strobe to ps2_keyboard
//   evt_valid      event available
//   evt_ready      consumer accepts the event
//   evt_code       final (non-prefix) scan code
//   evt_ext        E0 prefix preceded the code
//   evt_break      F0 prefix preceded the code (key release)
//   evt_repeat     typematic repeat of the currently held key
//   evt_ascii      ASCII translation, 0x00 if untranslatable
//   shift_flag     either shift key held
//   ctrl_flag      either ctrl key held
//   press_cnt      count of non-repeat make events, wraps
// ---------------------------------------------------------------------------
module ps2_key_event_decoder #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       kbd_data,
    input  logic             kbd_ready,
    output logic             kbd_nextdata_n,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [7:0]       evt_code,
    output logic             evt_ext,
    output logic             evt_break,
    output logic             evt_repeat,
    output logic [7:0]       evt_ascii,
    output logic             shift_flag,
    output logic             ctrl_flag,
    output logic [CNT_W-1:0] press_cnt
);

    typedef enum logic [1:0] {
        IDLE,
        POP,
        PROC,
        EMIT
    } state_t;

    state_t           state;
    state_t           state_nxt;

    logic [7:0]       byte_r;
    logic             ext_p;
    logic             brk_p;
    logic [8:0]       held_key;
    logic             held_valid;
    logic             shift_l;
    logic             shift_r;
    logic             ctrl_l;
    logic             ctrl_r;

    logic [8:0]       key_now;
    logic             is_e0;
    logic             is_f0;
    logic             is_discard;
    logic             is_repeat;
    logic             drop_evt;
    logic [7:0]       ascii_now;

    // Extended flag and code together identify a physical key.
    assign key_now    = {ext_p, byte_r};
    assign is_e0      = (byte_r == 8'hE0);
    assign is_f0      = (byte_r == 8'hF0);
    // 00/FF are keyboard error/overrun codes and E1 starts the Pause
    // sequence; none of them form an event and they cancel any prefix.
    assign is_discard = (byte_r == 8'h00) || (byte_r == 8'hFF) || (byte_r == 8'hE1);
    assign is_repeat  = !brk_p && held_valid && (held_key == key_now);

`ifdef PS2_REPEAT_FILTER_EN
    assign drop_evt = is_repeat;
`else
    assign drop_evt = 1'b0;
`endif

    assign shift_flag = shift_l | shift_r;
    assign ctrl_flag  = ctrl_l | ctrl_r;

    // Set-2 to ASCII translation. Only non-extended codes translate; the
    // shift state only affects letters.
    function automatic logic [7:0] ascii_lookup(
        input logic [7:0] code,
        input logic       ext,
        input logic       shift
    );
        logic [7:0] lower;
        logic       letter;
        lower  = 8'h00;
        letter = 1'b1;
        case (code)
            8'h1C: lower = 8'h61;
            8'h32: lower = 8'h62;
            8'h21: lower = 8'h63;
            8'h23: lower = 8'h64;
            8'h24: lower = 8'h65;
            8'h2B: lower = 8'h66;
            8'h34: lower = 8'h67;
            8'h33: lower = 8'h68;
            8'h43: lower = 8'h69;
            8'h3B: lower = 8'h6A;
            8'h42: lower = 8'h6B;
            8'h4B: lower = 8'h6C;
            8'h3A: lower = 8'h6D;
            8'h31: lower = 8'h6E;
            8'h44: lower = 8'h6F;
            8'h4D: lower = 8'h70;
            8'h15: lower = 8'h71;
            8'h2D: lower = 8'h72;
            8'h1B: lower = 8'h73;
            8'h2C: lower = 8'h74;
            8'h3C: lower = 8'h75;
            8'h2A: lower = 8'h76;
            8'h1D: lower = 8'h77;
            8'h22: lower = 8'h78;
            8'h35: lower = 8'h79;
            8'h1A: lower = 8'h7A;
            default: begin
                letter = 1'b0;
                case (code)
                    8'h45:   lower = 8'h30;
                    8'h16:   lower = 8'h31;
                    8'h1E:   lower = 8'h32;
                    8'h26:   lower = 8'h33;
                    8'h25:   lower = 8'h34;
                    8'h2E:   lower = 8'h35;
                    8'h36:   lower = 8'h36;
                    8'h3D:   lower = 8'h37;
                    8'h3E:   lower = 8'h38;
                    8'h46:   lower = 8'h39;
                    8'h29:   lower = 8'h20;
                    8'h5A:   lower = 8'h0D;
                    default: lower = 8'h00;
                endcase
            end
        endcase
        if (ext) begin
            ascii_lookup = 8'h00;
        end else if (letter && shift) begin
            ascii_lookup = lower - 8'h20;
        end else begin
            ascii_lookup = lower;
        end
    endfunction

    assign ascii_now = ascii_lookup(byte_r, ext_p, shift_flag);

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state and handshake outputs. The pop strobe is asserted only in
    // POP, and PROC deliberately ignores kbd_ready so the keyboard FIFO has a
    // cycle to advance its read pointer before the next byte is considered.
    always_comb begin
        state_nxt      = state;
        kbd_nextdata_n = 1'b1;
        evt_valid      = 1'b0;
        case (state)
            IDLE: begin
                if (kbd_ready) begin
                    state_nxt = POP;
                end
            end
            POP: begin
                kbd_nextdata_n = 1'b0;
                state_nxt      = PROC;
            end
            PROC: begin
                if (is_e0 || is_f0 || is_discard || drop_evt) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = EMIT;
                end
            end
            EMIT: begin
                evt_valid = 1'b1;
                if (evt_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath: byte capture, prefix tracking, event fields, modifier and
    // held-key bookkeeping. Event fields change only in PROC, so they stay
    // stable for the whole time the event waits in EMIT.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            byte_r     <= 8'h00;
            ext_p      <= 1'b0;
            brk_p      <= 1'b0;
            held_key   <= 9'h000;
            held_valid <= 1'b0;
            shift_l    <= 1'b0;
            shift_r    <= 1'b0;
            ctrl_l     <= 1'b0;
            ctrl_r     <= 1'b0;
            evt_code   <= 8'h00;
            evt_ext    <= 1'b0;
            evt_break  <= 1'b0;
            evt_repeat <= 1'b0;
            evt_ascii  <= 8'h00;
            press_cnt  <= '0;
        end else begin
            if (state == IDLE && kbd_ready) begin
                byte_r <= kbd_data;
            end
            if (state == PROC) begin
                if (is_e0) begin
                    ext_p <= 1'b1;
                end else if (is_f0) begin
                    brk_p <= 1'b1;
                end else begin
                    ext_p <= 1'b0;
                    brk_p <= 1'b0;
                    if (!is_discard) begin
                        if (!drop_evt) begin
                            evt_code   <= byte_r;
                            evt_ext    <= ext_p;
                            evt_break  <= brk_p;
`ifdef PS2_REPEAT_FILTER_EN
                            evt_repeat <= 1'b0;
`else
                            evt_repeat <= is_repeat;
`endif
                            evt_ascii  <= ascii_now;
                        end

                        // Each modifier key is tracked on its own so that
                        // releasing one shift/ctrl keeps the flag while the
                        // other is still down.
                        if (key_now == 9'h012) shift_l <= !brk_p;
                        if (key_now == 9'h059) shift_r <= !brk_p;
                        if (key_now == 9'h014) ctrl_l  <= !brk_p;
                        if (key_now == 9'h114) ctrl_r  <= !brk_p;

                        if (!brk_p) begin
                            if (!is_repeat) begin
                                held_key   <= key_now;
                                held_valid <= 1'b1;
                                press_cnt  <= press_cnt + CNT_W'(1);
                            end
                        end else if (held_valid && held_key == key_now) begin
                            held_valid <= 1'b0;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_ps2_key_event_decoder
//
// Self-checking bench for ps2_key_event_decoder. A queue stands in for the
// ps2_keyboard FIFO; a key-level reference model turns every pushed byte into
// the list of events a consumer should see, and captured handshakes are
// compared against it. Directed steps cover the main scenarios, then
// randomized byte streams with random consumer backpressure follow.
// ---------------------------------------------------------------------------
module tb_ps2_key_event_decoder;

   localparam int CNT_W = 3;

   typedef struct {
      logic [7:0]       code;
      logic             ext;
      logic             brk;
      logic             rep;
      logic [7:0]       ascii;
      logic             shift;
      logic             ctrl;
      logic [CNT_W-1:0] cnt;
   } ev_t;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [7:0]       kbd_data = 8'h00;
   logic             kbd_ready = 1'b0;
   logic             kbd_nextdata_n;
   logic             evt_valid;
   logic             evt_ready = 1'b0;
   logic [7:0]       evt_code;
   logic             evt_ext;
   logic             evt_break;
   logic             evt_repeat;
   logic [7:0]       evt_ascii;
   logic             shift_flag;
   logic             ctrl_flag;
   logic [CNT_W-1:0] press_cnt;

   int checks = 0;
   int errors = 0;

   logic [7:0] fifo [$];
   ev_t        got  [$];
   ev_t        expq [$];
   ev_t        cap;
   int         pops = 0;
   int         double_low = 0;
   logic       prev_low = 1'b0;

   // Reference model state: pending prefixes, individual modifier keys,
   // currently held key and the press counter.
   logic       m_ext, m_brk, m_ls, m_rs, m_lc, m_rc, m_hv;
   logic [8:0] m_held;
   int         m_cnt;

   logic [7:0] letter_tab [0:25] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                     8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                     8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                     8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
   logic [7:0] digit_tab [0:9]   = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                     8'h3D, 8'h3E, 8'h46};
   logic [7:0] pool [0:19]       = '{8'h1C, 8'h32, 8'h21, 8'h12, 8'h59, 8'h14, 8'h1B,
                                     8'h29, 8'h45, 8'h5A, 8'h16, 8'hE0, 8'hF0, 8'hE0,
                                     8'hF0, 8'h00, 8'hFF, 8'hE1, 8'h75, 8'h46};

   ps2_key_event_decoder #(.CNT_W(CNT_W)) dut (
      .clk            (clk),
      .rst            (rst),
      .kbd_data       (kbd_data),
      .kbd_ready      (kbd_ready),
      .kbd_nextdata_n (kbd_nextdata_n),
      .evt_valid      (evt_valid),
      .evt_ready      (evt_ready),
      .evt_code       (evt_code),
      .evt_ext        (evt_ext),
      .evt_break      (evt_break),
      .evt_repeat     (evt_repeat),
      .evt_ascii      (evt_ascii),
      .shift_flag     (shift_flag),
      .ctrl_flag      (ctrl_flag),
      .press_cnt      (press_cnt)
   );

   always #5 clk = ~clk;

   // FIFO stand-in and event monitor, evaluated on the falling edge so the
   // DUT outputs have settled. A low strobe pops one byte; a strobe low on
   // two consecutive samples is recorded as a malformed pulse.
   always @(negedge clk) begin
      if (!kbd_nextdata_n) begin
         if (prev_low) double_low++;
         pops++;
         if (fifo.size() > 0) void'(fifo.pop_front());
      end
      prev_low  = !kbd_nextdata_n;
      kbd_ready = (fifo.size() != 0);
      kbd_data  = kbd_ready ? fifo[0] : 8'h00;
      if (evt_valid && evt_ready) begin
         cap.code  = evt_code;
         cap.ext   = evt_ext;
         cap.brk   = evt_break;
         cap.rep   = evt_repeat;
         cap.ascii = evt_ascii;
         cap.shift = shift_flag;
         cap.ctrl  = ctrl_flag;
         cap.cnt   = press_cnt;
         got.push_back(cap);
      end
   end

   function automatic logic [7:0] ref_ascii(input logic [7:0] c, input logic ext, input logic sh);
      logic [7:0] a;
      a = 8'h00;
      if (!ext) begin
         for (int i = 0; i < 26; i++)
            if (letter_tab[i] == c) a = 8'((sh ? 8'h41 : 8'h61) + i);
         for (int i = 0; i < 10; i++)
            if (digit_tab[i] == c) a = 8'(8'h30 + i);
         if (c == 8'h29) a = 8'h20;
         if (c == 8'h5A) a = 8'h0D;
      end
      return a;
   endfunction

   function void model_reset();
      m_ext = 0; m_brk = 0; m_ls = 0; m_rs = 0; m_lc = 0; m_rc = 0; m_hv = 0;
      m_held = 9'h000;
      m_cnt = 0;
   endfunction

   // Key-level interpretation of one byte of the keyboard stream.
   function void model_byte(input logic [7:0] b);
      ev_t        e;
      logic [8:0] key;
      logic       rep;
      if (b == 8'hE0) begin
         m_ext = 1;
      end else if (b == 8'hF0) begin
         m_brk = 1;
      end else if (b == 8'h00 || b == 8'hFF || b == 8'hE1) begin
         m_ext = 0;
         m_brk = 0;
      end else begin
         key     = {m_ext, b};
         e.ascii = ref_ascii(b, m_ext, m_ls | m_rs);
         rep     = 0;
         if (!m_brk) begin
            rep = m_hv && (m_held == key);
            if (!rep) begin
               m_held = key;
               m_hv   = 1;
               m_cnt  = (m_cnt + 1) % (1 << CNT_W);
            end
         end else if (m_hv && m_held == key) begin
            m_hv = 0;
         end
         if (key == 9'h012) m_ls = !m_brk;
         if (key == 9'h059) m_rs = !m_brk;
         if (key == 9'h014) m_lc = !m_brk;
         if (key == 9'h114) m_rc = !m_brk;
         e.code  = b;
         e.ext   = m_ext;
         e.brk   = m_brk;
         e.rep   = rep;
         e.shift = m_ls | m_rs;
         e.ctrl  = m_lc | m_rc;
         e.cnt   = CNT_W'(m_cnt);
`ifdef PS2_REPEAT_FILTER_EN
         if (!rep) expq.push_back(e);
`else
         expq.push_back(e);
`endif
         m_ext = 0;
         m_brk = 0;
      end
   endfunction

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic applyStimulus(input logic [7:0] b);
      fifo.push_back(b);
      model_byte(b);
   endtask

   // Let the DUT consume everything queued with the consumer always ready.
   task automatic drain(input string tag);
      int quiet = 0;
      int n = 0;
      @(posedge clk); #1;
      evt_ready = 1'b1;
      while (quiet < 6 && n < 4000) begin
         @(negedge clk);
         n++;
         if (fifo.size() == 0 && !evt_valid && kbd_nextdata_n) quiet++;
         else quiet = 0;
      end
      checkOutput({tag, " drain_done"}, 32'(quiet >= 6), 32'd1);
   endtask

   task automatic compareEvents(input string tag);
      int n;
      checkOutput({tag, " event_count"}, got.size(), expq.size());
      n = (got.size() < expq.size()) ? got.size() : expq.size();
      for (int i = 0; i < n; i++) begin
         checkOutput($sformatf("%s ev%0d code", tag, i),   got[i].code,  expq[i].code);
         checkOutput($sformatf("%s ev%0d ext", tag, i),    got[i].ext,   expq[i].ext);
         checkOutput($sformatf("%s ev%0d break", tag, i),  got[i].brk,   expq[i].brk);
         checkOutput($sformatf("%s ev%0d repeat", tag, i), got[i].rep,   expq[i].rep);
         checkOutput($sformatf("%s ev%0d ascii", tag, i),  got[i].ascii, expq[i].ascii);
         checkOutput($sformatf("%s ev%0d shift", tag, i),  got[i].shift, expq[i].shift);
         checkOutput($sformatf("%s ev%0d ctrl", tag, i),   got[i].ctrl,  expq[i].ctrl);
         checkOutput($sformatf("%s ev%0d cnt", tag, i),    got[i].cnt,   expq[i].cnt);
      end
      got.delete();
      expq.delete();
   endtask

   initial begin
      int p0;
      int n;
      logic [7:0] last_make;
      model_reset();
      last_make = 8'h1C;

      // Reset values while rst is held low.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("reset nextdata_n", kbd_nextdata_n, 1'b1);
      checkOutput("reset evt_valid", evt_valid, 1'b0);
      checkOutput("reset press_cnt", press_cnt, 0);
      @(posedge clk); #1;
      rst = 1'b1;

      // Make and break of 'a': three single-cycle pops, two events.
      evt_ready = 1'b1;
      p0 = pops;
      applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h1C);
      drain("t1");
      checkOutput("t1 pops", pops - p0, 3);
      checkOutput("t1 strobe_width", double_low, 0);
      if (got.size() >= 2) begin
         checkOutput("t1 make ascii", got[0].ascii, 8'h61);
         checkOutput("t1 make cnt", got[0].cnt, 1);
         checkOutput("t1 break flag", got[1].brk, 1'b1);
         checkOutput("t1 break ascii", got[1].ascii, 8'h61);
      end
      compareEvents("t1");

      // Shifted letter.
      applyStimulus(8'h12); applyStimulus(8'h1C); applyStimulus(8'hF0);
      applyStimulus(8'h1C); applyStimulus(8'hF0); applyStimulus(8'h12);
      drain("t2");
      checkOutput("t2 events", got.size(), 4);
      if (got.size() == 4) begin
         checkOutput("t2 shift_after_make", got[0].shift, 1'b1);
         checkOutput("t2 upper_a", got[1].ascii, 8'h41);
         checkOutput("t2 shift_after_break", got[3].shift, 1'b0);
      end
      compareEvents("t2");

      // Typematic repeat.
      p0 = int'(press_cnt);
      applyStimulus(8'h1B); applyStimulus(8'h1B); applyStimulus(8'h1B);
      applyStimulus(8'hF0); applyStimulus(8'h1B);
      drain("t3");
`ifdef PS2_REPEAT_FILTER_EN
      checkOutput("t3 events", got.size(), 2);
`else
      checkOutput("t3 events", got.size(), 4);
      if (got.size() == 4) begin
         checkOutput("t3 rep1", got[1].rep, 1'b1);
         checkOutput("t3 rep2", got[2].rep, 1'b1);
         checkOutput("t3 rep_break", got[3].rep, 1'b0);
      end
`endif
      checkOutput("t3 press_cnt", press_cnt, (p0 + 1) % (1 << CNT_W));
      compareEvents("t3");

      // Extended keys, right ctrl.
      applyStimulus(8'hE0); applyStimulus(8'h75); applyStimulus(8'hE0); applyStimulus(8'h14);
      drain("t4");
      if (got.size() == 2) begin
         checkOutput("t4 ext", got[0].ext, 1'b1);
         checkOutput("t4 ascii", got[0].ascii, 8'h00);
         checkOutput("t4 ctrl", got[1].ctrl, 1'b1);
      end
      compareEvents("t4");

      // Backpressure: event held stable, nothing else popped.
      @(posedge clk); #1;
      evt_ready = 1'b0;
      p0 = pops;
      applyStimulus(8'h29); applyStimulus(8'h45); applyStimulus(8'h5A);
      repeat (20) @(negedge clk);
      checkOutput("t5 valid_held", evt_valid, 1'b1);
      checkOutput("t5 code_held", evt_code, 8'h29);
      checkOutput("t5 pops_stalled", pops - p0, 1);
      repeat (10) @(negedge clk);
      checkOutput("t5 code_stable", evt_code, 8'h29);
      checkOutput("t5 ascii_stable", evt_ascii, 8'h20);
      checkOutput("t5 pops_still", pops - p0, 1);
      drain("t5");
      if (got.size() == 3) begin
         checkOutput("t5 ascii0", got[0].ascii, 8'h20);
         checkOutput("t5 ascii1", got[1].ascii, 8'h30);
         checkOutput("t5 ascii2", got[2].ascii, 8'h0D);
      end
      compareEvents("t5");

      // Reset in the middle of an E0 sequence, with shift held.
      applyStimulus(8'h12);
      drain("t6a");
      compareEvents("t6a");
      p0 = pops;
      applyStimulus(8'hE0);
      n = 0;
      while (pops == p0 && n < 100) begin @(negedge clk); n++; end
      checkOutput("t6 e0_popped", pops - p0, 1);
      repeat (3) @(negedge clk);
      rst = 1'b0;
      #1;
      checkOutput("t6 rst valid", evt_valid, 1'b0);
      checkOutput("t6 rst nextdata_n", kbd_nextdata_n, 1'b1);
      checkOutput("t6 rst code", evt_code, 8'h00);
      checkOutput("t6 rst ext", evt_ext, 1'b0);
      checkOutput("t6 rst break", evt_break, 1'b0);
      checkOutput("t6 rst repeat", evt_repeat, 1'b0);
      checkOutput("t6 rst ascii", evt_ascii, 8'h00);
      checkOutput("t6 rst shift", shift_flag, 1'b0);
      checkOutput("t6 rst ctrl", ctrl_flag, 1'b0);
      checkOutput("t6 rst cnt", press_cnt, 0);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      applyStimulus(8'h1C);
      drain("t6");
      if (got.size() == 1) begin
         checkOutput("t6 ext_cleared", got[0].ext, 1'b0);
         checkOutput("t6 ascii_lower", got[0].ascii, 8'h61);
      end
      compareEvents("t6");

      // Randomized streams with random consumer backpressure.
      for (int r = 0; r < 8; r++) begin
         for (int c = 0; c < 60; c++) begin
            @(posedge clk); #1;
            evt_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) begin
               case ($urandom_range(0, 5))
                  0:       applyStimulus(last_make);
                  1:       applyStimulus(8'($urandom));
                  default: begin
                     applyStimulus(pool[$urandom_range(0, 19)]);
                     if (fifo[$] != 8'hE0 && fifo[$] != 8'hF0) last_make = fifo[$];
                  end
               endcase
            end
         end
         drain($sformatf("rnd%0d", r));
         compareEvents($sformatf("rnd%0d", r));
      end
      checkOutput("final strobe_width", double_low, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
